// File: rtl/aes_sched_pkg.sv
// Shared types for the AES job scheduler: FSM states, register indices, job record.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package aes_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  localparam logic [2:0] REG_DATA_ADDR  = 3'd0;
  localparam logic [2:0] REG_KEY_ADDR   = 3'd1;
  localparam logic [2:0] REG_WRITE_ADDR = 3'd2;
  localparam logic [2:0] REG_CTRL       = 3'd3;
  localparam logic [2:0] REG_STATUS     = 3'd4;

  typedef struct packed {
    logic [16:0] data_addr;
    logic [15:0] key_addr;
    logic [15:0] write_addr;
    logic [9:0]  words;
    logic        mode;       // 0 encrypt, 1 decrypt
  } job_t;

endpackage

// File: rtl/aes_job_fifo.sv
// Synchronous job FIFO holding job_t records between the register port and the issue FSM.
// Latency: a push is visible (count/empty) one cycle later; pop_job is the head entry, read combinationally.
// Backpressure: pushes while full and pops while empty are ignored; full/empty come from the registered count.
// Ports: push/push_job write side, pop/pop_job read side, full/empty/count status.
module aes_job_fifo
  import aes_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_processor,
  input  logic                     reset,
  input  logic                     push,
  input  job_t                     push_job,
  input  logic                     pop,
  output job_t                     pop_job,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  job_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_job = mem[rd_ptr];

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk_processor) begin
    if (do_push) begin
      mem[wr_ptr] <= push_job;
    end
  end

  // DEPTH is a power of two, so pointers wrap modulo DEPTH naturally.
  always_ff @(posedge clk_processor) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/aes_job_scheduler.sv
// Queues AES jobs from MMIO writes and issues them one at a time to the AES datapath, timing completion by latency count.
// Latency: pulse one cycle after the CTRL write; done/irq LAT_BASE+words*LAT_PER_WORD+1 cycles after the pulse.
// Backpressure: CTRL pushes to a full queue are dropped and flagged err_ovf; zero-word pushes are dropped and flagged err_zero.
// Ports: cfg_* register port (cfg_rdata combinational); aes_encrypt/aes_decrypt start pulses plus held operands; busy; irq (= STATUS.done).
module aes_job_scheduler
  import aes_sched_pkg::*;
#(
  parameter int QUEUE_DEPTH  = 4,
  parameter int LAT_BASE     = 48,
  parameter int LAT_PER_WORD = 2
) (
  input  logic        clk_processor,
  input  logic        reset,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic        aes_encrypt,
  output logic        aes_decrypt,
  output logic [16:0] data_addr,
  output logic [15:0] key_addr,
  output logic [15:0] write_addr,
  output logic [9:0]  no_of_words,
  output logic        busy,
  output logic        irq
);

  localparam int          CNT_W       = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [15:0] LAT_BASE_16 = 16'(LAT_BASE);
  localparam logic [15:0] LAT_WORD_16 = 16'(LAT_PER_WORD);

  state_t             state;
  state_t             state_next;
  logic [16:0]        stage_data;
  logic [15:0]        stage_key;
  logic [15:0]        stage_write;
  logic [31:0]        ctrl_reg;
  logic               done;
  logic               err_ovf;
  logic               err_zero;
  logic [7:0]         jobs_completed;
  logic [15:0]        lat_cnt;
  logic               mode;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;
  logic [2:0]         count_sat;
  job_t               push_job;
  job_t               pop_job;
  logic               ctrl_wr;
  logic               status_wr;
  logic               push_zero;
  logic               fifo_push;
  logic               fifo_pop;
  logic               job_finish;

  assign ctrl_wr    = cfg_we && (cfg_addr == REG_CTRL);
  assign status_wr  = cfg_we && (cfg_addr == REG_STATUS);
  assign push_zero  = (cfg_wdata[9:0] == 10'd0);
  assign fifo_push  = ctrl_wr && !push_zero && !fifo_full;
  assign fifo_pop   = (state == IDLE) && !fifo_empty;
  assign job_finish = (state == WAIT) && (lat_cnt <= 16'd1);
  assign push_job   = {stage_data, stage_key, stage_write, cfg_wdata[9:0], cfg_wdata[16]};
  assign count_sat  = (32'(fifo_count) > 32'd7) ? 3'd7 : 3'(fifo_count);
  assign irq        = done;

  aes_job_fifo #(
    .DEPTH(QUEUE_DEPTH)
  ) u_fifo (
    .clk_processor (clk_processor),
    .reset         (reset),
    .push          (fifo_push),
    .push_job      (push_job),
    .pop           (fifo_pop),
    .pop_job       (pop_job),
    .full          (fifo_full),
    .empty         (fifo_empty),
    .count         (fifo_count)
  );

  always_ff @(posedge clk_processor) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Pulses live only in ISSUE, which lasts exactly one cycle.
  always_comb begin
    state_next  = state;
    aes_encrypt = 1'b0;
    aes_decrypt = 1'b0;
    busy        = 1'b0;
    case (state)
      IDLE:  if (!fifo_empty) state_next = ISSUE;
      ISSUE: begin
        state_next  = WAIT;
        aes_encrypt = !mode;
        aes_decrypt = mode;
        busy        = 1'b1;
      end
      WAIT: begin
        busy = 1'b1;
        if (lat_cnt <= 16'd1) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_processor) begin
    if (reset) begin
      stage_data     <= '0;
      stage_key      <= '0;
      stage_write    <= '0;
      ctrl_reg       <= '0;
      done           <= 1'b0;
      err_ovf        <= 1'b0;
      err_zero       <= 1'b0;
      jobs_completed <= '0;
      lat_cnt        <= '0;
      mode           <= 1'b0;
      data_addr      <= '0;
      key_addr       <= '0;
      write_addr     <= '0;
      no_of_words    <= '0;
    end else begin
      if (cfg_we) begin
        case (cfg_addr)
          REG_DATA_ADDR:  stage_data  <= cfg_wdata[16:0];
          REG_KEY_ADDR:   stage_key   <= cfg_wdata[15:0];
          REG_WRITE_ADDR: stage_write <= cfg_wdata[15:0];
          REG_CTRL:       ctrl_reg    <= cfg_wdata;
          default:        ;
        endcase
      end

      if (ctrl_wr && push_zero)                   err_zero <= 1'b1;
      else if (status_wr && cfg_wdata[4])         err_zero <= 1'b0;

      if (ctrl_wr && !push_zero && fifo_full)     err_ovf  <= 1'b1;
      else if (status_wr && cfg_wdata[3])         err_ovf  <= 1'b0;

      // Completion beats a same-cycle W1C so a finished job is never lost.
      if (job_finish)                             done     <= 1'b1;
      else if (status_wr && cfg_wdata[0])         done     <= 1'b0;

      if (job_finish) jobs_completed <= jobs_completed + 8'd1;

      // Operands change only on a pop, so they hold through ISSUE and WAIT.
      if (fifo_pop) begin
        data_addr   <= pop_job.data_addr;
        key_addr    <= pop_job.key_addr;
        write_addr  <= pop_job.write_addr;
        no_of_words <= pop_job.words;
        mode        <= pop_job.mode;
      end

      if (state == ISSUE)     lat_cnt <= LAT_BASE_16 + 16'(no_of_words) * LAT_WORD_16;
      else if (state == WAIT) lat_cnt <= lat_cnt - 16'd1;
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      REG_DATA_ADDR:  cfg_rdata[16:0] = stage_data;
      REG_KEY_ADDR:   cfg_rdata[15:0] = stage_key;
      REG_WRITE_ADDR: cfg_rdata[15:0] = stage_write;
      REG_CTRL:       cfg_rdata       = ctrl_reg;
      REG_STATUS: begin
        cfg_rdata[0]     = done;
        cfg_rdata[1]     = busy;
        cfg_rdata[2]     = fifo_full;
        cfg_rdata[3]     = err_ovf;
        cfg_rdata[4]     = err_zero;
        cfg_rdata[7:5]   = count_sat;
        cfg_rdata[23:16] = jobs_completed;
      end
      default: cfg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Randomized and directed bench for aes_job_scheduler against a queue/timestamp reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_aes_job_scheduler;

  localparam int DEPTH = 4;
  localparam int LB    = 48;
  localparam int LPW   = 2;

  logic        clk_processor = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        aes_encrypt;
  logic        aes_decrypt;
  logic [16:0] data_addr;
  logic [15:0] key_addr;
  logic [15:0] write_addr;
  logic [9:0]  no_of_words;
  logic        busy;
  logic        irq;

  always #5 clk_processor = ~clk_processor;

  aes_job_scheduler dut (
    .clk_processor (clk_processor),
    .reset         (reset),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_wdata     (cfg_wdata),
    .cfg_rdata     (cfg_rdata),
    .aes_encrypt   (aes_encrypt),
    .aes_decrypt   (aes_decrypt),
    .data_addr     (data_addr),
    .key_addr      (key_addr),
    .write_addr    (write_addr),
    .no_of_words   (no_of_words),
    .busy          (busy),
    .irq           (irq)
  );

  // Reference model: a job queue plus absolute edge timestamps for the job in flight.
  typedef struct {
    logic [16:0] d;
    logic [15:0] k;
    logic [15:0] w;
    logic [9:0]  n;
    logic        m;
  } mjob_t;

  mjob_t       q[$];
  mjob_t       cur;
  int          total;
  int          bad;
  int          cyc;
  bit          act;
  int          pop_edge;
  int          done_edge;
  bit          m_done;
  bit          m_ovf;
  bit          m_zero;
  int          m_jobs;
  logic [16:0] s_d;
  logic [15:0] s_k;
  logic [15:0] s_w;
  logic [31:0] s_ctrl;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @edge %0d: got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    cur       = '{default: '0};
    act       = 1'b0;
    pop_edge  = -1;
    done_edge = -1;
    m_done    = 1'b0;
    m_ovf     = 1'b0;
    m_zero    = 1'b0;
    m_jobs    = 0;
    s_d       = '0;
    s_k       = '0;
    s_w       = '0;
    s_ctrl    = '0;
  endtask

  task automatic model_edge(input bit r, input bit we, input logic [2:0] a, input logic [31:0] wd);
    int pre;
    bit was_act;
    bit done_set;
    cyc++;
    if (r) begin
      model_clear();
      return;
    end
    was_act  = act;
    done_set = 1'b0;
    if (act && cyc == done_edge) begin
      act      = 1'b0;
      done_set = 1'b1;
      m_jobs   = (m_jobs + 1) % 256;
    end
    pre = q.size();
    if (!was_act && pre > 0) begin
      cur       = q.pop_front();
      act       = 1'b1;
      pop_edge  = cyc;
      done_edge = cyc + 1 + LB + LPW * int'(cur.n);
    end
    if (we) begin
      case (a)
        3'd0: s_d = wd[16:0];
        3'd1: s_k = wd[15:0];
        3'd2: s_w = wd[15:0];
        3'd3: begin
          s_ctrl = wd;
          if (wd[9:0] == 10'd0)  m_zero = 1'b1;
          else if (pre >= DEPTH) m_ovf  = 1'b1;
          else q.push_back('{s_d, s_k, s_w, wd[9:0], wd[16]});
        end
        3'd4: begin
          if (wd[0]) m_done = 1'b0;
          if (wd[3]) m_ovf  = 1'b0;
          if (wd[4]) m_zero = 1'b0;
        end
        default: ;
      endcase
    end
    if (done_set) m_done = 1'b1;
  endtask

  function automatic logic [63:0] exp_out();
    bit pulse;
    pulse = act && (cyc == pop_edge);
    return {1'b0, pulse && !cur.m, pulse && cur.m, act, m_done, cur.d, cur.k, cur.w, cur.n};
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    int qs;
    qs       = q.size();
    s        = '0;
    s[0]     = m_done;
    s[1]     = act;
    s[2]     = (qs >= DEPTH);
    s[3]     = m_ovf;
    s[4]     = m_zero;
    s[7:5]   = (qs > 7) ? 3'd7 : 3'(qs);
    s[23:16] = 8'(m_jobs);
    return s;
  endfunction

  // One clock: the edge consumes the currently driven inputs, then outputs and STATUS are checked.
  task automatic step();
    bit          r;
    bit          w;
    logic [2:0]  a;
    logic [31:0] d;
    r = reset;
    w = cfg_we;
    a = cfg_addr;
    d = cfg_wdata;
    @(posedge clk_processor);
    model_edge(r, w, a, d);
    #1;
    check_val("outputs", {1'b0, aes_encrypt, aes_decrypt, busy, irq, data_addr, key_addr, write_addr, no_of_words}, exp_out());
    cfg_we    = 1'b0;
    reset     = 1'b0;
    cfg_addr  = 3'd4;
    cfg_wdata = '0;
    #1;
    check_val("status", {32'd0, cfg_rdata}, {32'd0, exp_status()});
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    step();
  endtask

  // Only one read per cycle: call between steps.
  task automatic rd_chk(input logic [2:0] a);
    logic [31:0] e;
    cfg_addr = a;
    #1;
    case (a)
      3'd0:    e = {15'd0, s_d};
      3'd1:    e = {16'd0, s_k};
      3'd2:    e = {16'd0, s_w};
      3'd3:    e = s_ctrl;
      3'd4:    e = exp_status();
      default: e = '0;
    endcase
    check_val($sformatf("read%0d", a), {32'd0, cfg_rdata}, {32'd0, e});
    cfg_addr = 3'd4;
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while ((act || q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check_val("idle_budget", {63'd0, (act || q.size() != 0)}, 64'd0);
    step();
  endtask

  initial begin
    logic [31:0] d;
    int          n;
    total     = 0;
    bad       = 0;
    cyc       = 0;
    reset     = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = 3'd4;
    cfg_wdata = '0;
    model_clear();
    step();
    step();
    for (int i = 0; i < 8; i++) begin
      rd_chk(3'(i));
      step();
    end

    // Single encrypt
    wr(3'd0, 32'h100);
    wr(3'd1, 32'h10000);
    wr(3'd2, 32'h200);
    wr(3'd3, 32'h4);
    run_idle(500);
    rd_chk(3'd4);
    step();

    // Back-to-back encrypt then decrypt
    wr(3'd3, 32'h2);
    wr(3'd3, 32'h10001);
    run_idle(500);

    // Overflow while busy, then W1C of err_ovf alone
    wr(3'd3, 32'h1);
    step();
    step();
    for (int i = 0; i < 5; i++) wr(3'd3, 32'(i + 1));
    rd_chk(3'd3);
    step();
    wr(3'd4, 32'h8);
    rd_chk(3'd4);
    step();
    run_idle(2000);
    wr(3'd4, 32'h19);

    // Zero-word push
    wr(3'd3, 32'h10000);
    repeat (4) step();
    wr(3'd4, 32'h10);

    // Reset in the middle of WAIT
    wr(3'd0, 32'h1ABCD);
    wr(3'd3, 32'h3);
    repeat (20) step();
    reset = 1'b1;
    step();
    repeat (120) step();

    // Randomized traffic
    repeat (900) begin
      n = $urandom_range(0, 15);
      d = $urandom();
      case (n)
        0, 1: begin
          d[9:0] = 10'($urandom_range(0, 5));
          wr(3'd3, d);
        end
        2: wr(3'($urandom_range(0, 7)), d);
        3: wr(3'd4, d);
        4: begin
          rd_chk(3'($urandom_range(0, 7)));
          step();
        end
        default: step();
      endcase
    end
    run_idle(3000);

    // jobs_completed wrap after 256 one-word jobs
    reset = 1'b1;
    step();
    n = 0;
    while (n < 256) begin
      if (q.size() < DEPTH) begin
        wr(3'd3, 32'h1);
        n++;
      end else begin
        step();
      end
    end
    run_idle(2000);
    rd_chk(3'd4);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
